// File: rtl/iobus_pkg.sv
// Shared types and codes for the q2a peripheral bus sequencer.
package iobus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    localparam logic [1:0] DEV_LCD  = 2'd0;
    localparam logic [1:0] DEV_BTN  = 2'd1;
    localparam logic [1:0] DEV_EXP  = 2'd2;
    localparam logic [1:0] DEV_NONE = 2'd3;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_SCAN = 1'b1;

    function automatic logic [2:0] dev_onehot(input logic [1:0] dev);
        logic [2:0] oh;
        oh = 3'b000;
        if (dev != DEV_NONE) oh[dev] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/iobus_rr_arb.sv
// Two-way round-robin arbiter; pointer remembers the last requester served.
module iobus_rr_arb
    import iobus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_cpu,
    input  logic req_scan,
    output logic take,
    output logic gnt_id
);

    logic last;

    always_comb begin
        take   = en && (req_cpu || req_scan);
        gnt_id = REQ_CPU;
        if (req_cpu && req_scan)
            gnt_id = (last == REQ_CPU) ? REQ_SCAN : REQ_CPU;
        else if (req_scan)
            gnt_id = REQ_SCAN;
    end

    // Reset value makes the CPU the first winner of a tie.
    always_ff @(posedge clk) begin
        if (rst)
            last <= REQ_SCAN;
        else if (take)
            last <= gnt_id;
    end

endmodule

// File: rtl/iobus_sched.sv
// iobus sequencer: arbitrates CPU and scan engine, times select/strobe/hold
// and the LCD recovery gap behind the ttl245 transceiver.
module iobus_sched
    import iobus_pkg::*;
#(
    parameter int SETUP       = 1,
    parameter int PULSE       = 3,
    parameter int HOLD        = 1,
    parameter int LCD_RECOVER = 20,
    parameter int CW          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_wr,
    input  logic       cpu_cmd,
    input  logic [1:0] cpu_dev,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic       cpu_ack,
    input  logic       scan_req,
    output logic [7:0] scan_din,
    output logic       scan_ack,
    input  logic [7:0] iobus_in,
    output logic [7:0] iobus_out,
    output logic       iobus_oe,
    output logic [2:0] ioen,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic       btn_rd,
    output logic       x_strb,
    output logic       busy
);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          own, wr_q, cmd_q;
    logic [1:0]    dev_q;
    logic [7:0]    dout_q, rdata;
    logic          none_pend;

    logic          take, gnt_id, grant, capture, ack_ev, active, strobe;
    logic [1:0]    g_dev;

    // Held off while an unmapped ack is pending so a still-high cpu_req is not re-granted.
    iobus_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_IDLE && !none_pend),
        .req_cpu (cpu_req),
        .req_scan(scan_req),
        .take    (take),
        .gnt_id  (gnt_id)
    );

    assign g_dev = (gnt_id == REQ_SCAN) ? DEV_BTN : cpu_dev;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant   = 1'b0;
        capture = 1'b0;
        ack_ev  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    grant = 1'b1;
                    if (g_dev != DEV_NONE) begin
                        state_n = ST_SETUP;
                        cnt_n   = CW'(SETUP - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_n = ST_STROBE;
                    cnt_n   = CW'(PULSE - 1);
                end else cnt_n = cnt - 1'b1;
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_n = ST_HOLD;
                    cnt_n   = CW'(HOLD - 1);
                end else cnt_n = cnt - 1'b1;
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    ack_ev = 1'b1;
                    if (dev_q == DEV_LCD && LCD_RECOVER > 0) begin
                        state_n = ST_RECOVER;
                        cnt_n   = CW'(LCD_RECOVER - 1);
                    end else state_n = ST_IDLE;
                end else cnt_n = cnt - 1'b1;
            end
            ST_RECOVER: begin
                if (cnt == '0) state_n = ST_IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        active    = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
        strobe    = (state == ST_STROBE);
        ioen      = active ? dev_onehot(dev_q) : 3'b000;
        lcd_rs    = active && dev_q == DEV_LCD && cmd_q;
        iobus_oe  = active && wr_q;
        iobus_out = active ? dout_q : 8'h00;
        lcd_e     = strobe && dev_q == DEV_LCD;
        btn_rd    = strobe && dev_q == DEV_BTN;
        x_strb    = strobe && dev_q == DEV_EXP;
        busy      = (state != ST_IDLE);
        cpu_ack   = none_pend || (ack_ev && own == REQ_CPU);
        scan_ack  = ack_ev && own == REQ_SCAN;
        cpu_din   = (ack_ev && own == REQ_CPU)  ? rdata : 8'h00;
        scan_din  = (ack_ev && own == REQ_SCAN) ? rdata : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            own       <= REQ_CPU;
            wr_q      <= 1'b0;
            cmd_q     <= 1'b0;
            dev_q     <= DEV_LCD;
            dout_q    <= 8'h00;
            rdata     <= 8'h00;
            none_pend <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            none_pend <= grant && g_dev == DEV_NONE;
            if (grant) begin
                own    <= gnt_id;
                dev_q  <= g_dev;
                wr_q   <= (gnt_id == REQ_SCAN) ? 1'b0  : cpu_wr;
                cmd_q  <= (gnt_id == REQ_SCAN) ? 1'b0  : cpu_cmd;
                dout_q <= (gnt_id == REQ_SCAN) ? 8'h00 : cpu_dout;
                rdata  <= 8'h00;
            end
            if (capture) rdata <= wr_q ? 8'h00 : iobus_in;
        end
    end

endmodule

// File: tb/tb_iobus_sched.sv
// Scoreboard bench for iobus_sched: expected acks are queued at request time
// and matched (owner, data, cycle) when the DUT acks.
module tb_iobus_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_wr, cpu_cmd;
    logic [1:0] cpu_dev;
    logic [7:0] cpu_dout, cpu_din;
    logic       cpu_ack;
    logic       scan_req;
    logic [7:0] scan_din;
    logic       scan_ack;
    logic [7:0] iobus_in, iobus_out;
    logic       iobus_oe;
    logic [2:0] ioen;
    logic       lcd_rs, lcd_e, btn_rd, x_strb, busy;

    typedef struct {
        bit         is_cpu;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    iobus_sched dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_cmd(cpu_cmd), .cpu_dev(cpu_dev),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
        .scan_req(scan_req), .scan_din(scan_din), .scan_ack(scan_ack),
        .iobus_in(iobus_in), .iobus_out(iobus_out), .iobus_oe(iobus_oe),
        .ioen(ioen), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .btn_rd(btn_rd),
        .x_strb(x_strb), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ack scoreboard plus per-cycle output hygiene.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_ack || scan_ack) begin
            checks++;
            if (cpu_ack && scan_ack) begin
                failures++;
                $display("FAIL dual_ack cyc=%0d cpu_ack=1 scan_ack=1 required at most one", cyc);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack cyc=%0d cpu_ack=%b scan_ack=%b required none", cyc, cpu_ack, scan_ack);
            end else begin
                e = sb.pop_front();
                if (cpu_ack !== e.is_cpu || e.cyc !== cyc ||
                    (cpu_ack ? cpu_din : scan_din) !== e.data) begin
                    failures++;
                    $display("FAIL ack_match got cpu=%b cyc=%0d data=%h required cpu=%b cyc=%0d data=%h",
                             cpu_ack, cyc, cpu_ack ? cpu_din : scan_din, e.is_cpu, e.cyc, e.data);
                end
            end
        end
        checks++;
        if ((ioen & (ioen - 3'd1)) != 3'd0 || (iobus_oe && ioen == 3'd0) ||
            (32'(lcd_e) + 32'(btn_rd) + 32'(x_strb)) > 1) begin
            failures++;
            $display("FAIL hygiene cyc=%0d ioen=%b oe=%b strobes=%b%b%b", cyc, ioen, iobus_oe, lcd_e, btn_rd, x_strb);
        end
    end

    task automatic test_reset();
        rst = 1'b1; cpu_req = 0; cpu_wr = 0; cpu_cmd = 0; cpu_dev = 0; cpu_dout = 0;
        scan_req = 0; iobus_in = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_ack, scan_ack, iobus_out, iobus_oe, ioen, lcd_rs, lcd_e, btn_rd, x_strb, busy, cpu_din, scan_din} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs got oe=%b ioen=%b busy=%b out=%h required all zero", iobus_oe, ioen, busy, iobus_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lcd_write();
        int t0;
        cpu_req = 1; cpu_wr = 1; cpu_cmd = 1; cpu_dev = 2'd0; cpu_dout = 8'h38;
        t0 = cyc;
        sb.push_back('{1'b1, 8'h00, t0 + 5});
        for (int off = 1; off <= 27; off++) begin
            @(negedge clk);
            if (cpu_ack) cpu_req = 0;
            if (off <= 5) begin
                checks++;
                if ({ioen, lcd_rs, iobus_oe, iobus_out} !== {3'b001, 1'b1, 1'b1, 8'h38}) begin
                    failures++;
                    $display("FAIL lcd_wr_bus off=%0d got ioen=%b rs=%b oe=%b out=%h required 001 1 1 38", off, ioen, lcd_rs, iobus_oe, iobus_out);
                end
            end
            checks++;
            if (lcd_e !== (off >= 2 && off <= 4)) begin
                failures++;
                $display("FAIL lcd_wr_e off=%0d got %b required %b", off, lcd_e, (off >= 2 && off <= 4));
            end
            checks++;
            if (busy !== (off <= 25)) begin
                failures++;
                $display("FAIL lcd_wr_busy off=%0d got %b required %b", off, busy, (off <= 25));
            end
        end
    endtask

    task automatic test_scan_read();
        int n;
        n = 0;
        iobus_in = 8'hA5; scan_req = 1;
        sb.push_back('{1'b0, 8'hA5, cyc + 5});
        for (int off = 1; off <= 7; off++) begin
            @(negedge clk);
            if (scan_ack) scan_req = 0;
            if (btn_rd) n++;
            checks++;
            if (iobus_oe !== 1'b0 || lcd_e !== 1'b0) begin
                failures++;
                $display("FAIL scan_bus off=%0d got oe=%b lcd_e=%b required 0 0", off, iobus_oe, lcd_e);
            end
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL scan_btn_rd_len got %0d required 3", n);
        end
    endtask

    task automatic test_back_to_back();
        int t0, acks;
        acks = 0;
        iobus_in = 8'h5A;
        cpu_req = 1; cpu_wr = 0; cpu_cmd = 0; cpu_dev = 2'd1; cpu_dout = 8'hEE;
        scan_req = 1;
        t0 = cyc;
        sb.push_back('{1'b1, 8'h5A, t0 + 5});
        sb.push_back('{1'b0, 8'h5A, t0 + 11});
        sb.push_back('{1'b1, 8'h5A, t0 + 17});
        for (int off = 1; off <= 22; off++) begin
            @(negedge clk);
            if (cpu_ack || scan_ack) acks++;
            if (acks == 3) begin cpu_req = 0; scan_req = 0; end
        end
        checks++;
        if (acks != 3) begin
            failures++;
            $display("FAIL b2b_ack_count got %0d required 3", acks);
        end
    endtask

    task automatic test_recover_wait();
        int t0;
        cpu_req = 1; cpu_wr = 1; cpu_cmd = 0; cpu_dev = 2'd0; cpu_dout = 8'h01;
        t0 = cyc;
        sb.push_back('{1'b1, 8'h00, t0 + 5});
        for (int off = 1; off <= 33; off++) begin
            @(negedge clk);
            if (cpu_ack) cpu_req = 0;
            if (off == 10) begin
                cpu_req = 1; cpu_wr = 0; cpu_dev = 2'd1; iobus_in = 8'h3C;
                sb.push_back('{1'b1, 8'h3C, t0 + 31});
            end
            if (off >= 6 && off <= 25) begin
                checks++;
                if (ioen !== 3'b000 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL recover_bus off=%0d got ioen=%b busy=%b required 000 1", off, ioen, busy);
                end
            end
            if (off == 26) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL recover_end off=26 got busy=%b required 0", busy);
                end
            end
        end
    endtask

    task automatic test_unmapped();
        cpu_req = 1; cpu_wr = 1; cpu_cmd = 1; cpu_dev = 2'd3; cpu_dout = 8'hFF;
        sb.push_back('{1'b1, 8'h00, cyc + 1});
        for (int off = 1; off <= 6; off++) begin
            @(negedge clk);
            if (cpu_ack) cpu_req = 0;
            checks++;
            if ({ioen, lcd_e, btn_rd, x_strb, iobus_oe, busy} !== 8'd0) begin
                failures++;
                $display("FAIL unmapped_bus off=%0d got ioen=%b strb=%b%b%b oe=%b busy=%b required zero", off, ioen, lcd_e, btn_rd, x_strb, iobus_oe, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        cpu_req = 1; cpu_wr = 1; cpu_cmd = 1; cpu_dev = 2'd0; cpu_dout = 8'h30;
        repeat (3) @(negedge clk);
        checks++;
        if (lcd_e !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got lcd_e=%b required 1", lcd_e);
        end
        rst = 1; cpu_req = 0;
        @(negedge clk);
        checks++;
        if ({lcd_e, ioen, iobus_oe, busy, cpu_ack} !== 7'd0) begin
            failures++;
            $display("FAIL rstmid_abort got lcd_e=%b ioen=%b oe=%b busy=%b ack=%b required zero", lcd_e, ioen, iobus_oe, busy, cpu_ack);
        end
        rst = 0;
        repeat (8) @(negedge clk);
        iobus_in = 8'h81; scan_req = 1;
        sb.push_back('{1'b0, 8'h81, cyc + 5});
        for (int off = 1; off <= 7; off++) begin
            @(negedge clk);
            if (scan_ack) scan_req = 0;
            if (btn_rd) n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL rstmid_fresh btn_rd cycles got %0d required 3", n);
        end
    endtask

    initial begin
        test_reset();
        test_lcd_write();
        test_scan_read();
        test_back_to_back();
        test_recover_wait();
        test_unmapped();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL pending_acks got %0d outstanding required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iobus_sched.md
Name: iobus_sched

Overview:
- Sequences and arbitrates the 8-bit peripheral bus (iobus) behind the ttl245 transceiver on the q2a board.
- Two requesters share it: the CPU I/O path, which does reads and writes to any device, and the front-panel scan engine, which only reads the buttons.
- Generates device select (ioen), transceiver direction, LCD RS and strobe timing, and the post-access LCD recovery wait.
- Sits between the io decoder and the lcd/buttons/expansion devices.

Parameters:
- SETUP, 1: cycles select/RS/data are stable before the strobe (>=1).
- PULSE, 3: cycles the strobe is high (>=1).
- HOLD, 1: cycles select/data are held after the strobe falls (>=1).
- LCD_RECOVER, 20: idle cycles enforced after any LCD access before the next grant (>=0).
- CW, 8: width of the timing counter; every parameter must be < 2**CW.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_req  in  1  CPU access request; level, held until cpu_ack
- cpu_wr  in  1  1=write, 0=read; valid while cpu_req
- cpu_cmd  in  1  LCD register select (drives lcd_rs); valid while cpu_req
- cpu_dev  in  2  target device: 0=LCD, 1=buttons, 2=expansion, 3=unmapped
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CPU read data; valid when cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- scan_req  in  1  scan-engine button read request; level
- scan_din  out  8  scan read data; valid when scan_ack=1
- scan_ack  out  1  one-cycle completion pulse
- iobus_in  in  8  bus read data from the transceiver
- iobus_out  out  8  bus write data
- iobus_oe  out  1  1 = drive bus (ttl245 A->B)
- ioen  out  3  one-hot device select
- lcd_rs  out  1  LCD register select
- lcd_e  out  1  LCD enable strobe
- btn_rd  out  1  buttons read strobe
- x_strb  out  1  expansion strobe
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. A single CW-bit down-counter times SETUP, STROBE, HOLD and RECOVER.
- Reset: state=IDLE; counter=0; RR pointer favours CPU; all outputs 0; iobus_out=0; bus released (iobus_oe=0, ioen=000).
- IDLE grant rules:
  - Only one requester active: that requester wins.
  - Both active: the requester not granted last wins (round-robin).
  - On grant, latch requester, wr, cmd, dev and dout, then go to SETUP with counter=SETUP-1.
  - A scan grant is forced to dev=1, wr=0.
- Unmapped device (cpu_dev=3): granted as normal but no bus cycle. cpu_ack pulses the next cycle with cpu_din=0. State stays IDLE; the RR pointer is updated.
- SETUP:
  - ioen = one-hot(dev); lcd_rs = cmd (LCD only, else 0).
  - iobus_oe = wr; iobus_out = latched dout.
  - Go to STROBE with counter=PULSE-1 when counter=0.
- STROBE:
  - The selected strobe (lcd_e, btn_rd or x_strb) is high for exactly PULSE cycles.
  - For reads, iobus_in is captured on the last STROBE cycle.
  - Go to HOLD with counter=HOLD-1.
- HOLD:
  - All strobes low; ioen, rs and data unchanged.
  - On the last HOLD cycle, the owner's ack pulses, and cpu_din or scan_din presents the captured byte (0 for writes).
  - Next state: RECOVER (counter=LCD_RECOVER-1) if dev=0 and LCD_RECOVER>0; otherwise IDLE.
- RECOVER: bus released, ioen=000. Go to IDLE when counter=0. Requests arriving during RECOVER wait; none are dropped.
- Latency: ack is asserted SETUP+PULSE+HOLD cycles after the grant cycle. With defaults, a request sampled at cycle 0 gets its ack at cycle 5.
- Output hygiene:
  - Strobes are never high outside STROBE.
  - ioen is never multi-hot.
  - iobus_oe=1 only when ioen is non-zero and wr=1.
- Changes to request inputs after grant are ignored until ack.
- A requester that drops req before ack still completes its cycle; its ack pulses regardless.
- Reset mid-cycle: immediate return to reset values on the next edge. No ack for the aborted transfer.

Decomposition:
- Shared package iobus_pkg holds:
  - state encoding;
  - device codes DEV_LCD=0, DEV_BTN=1, DEV_EXP=2, DEV_NONE=3;
  - requester IDs REQ_CPU, REQ_SCAN.
- One sub-module, iobus_rr_arb: two-way round-robin arbiter with a registered last-grant pointer, evaluated only in IDLE.

Test Plan:
- CPU LCD write (dev=0, cmd=1, dout=0x38) from idle:
  - lcd_rs=1 and ioen=001 from cycle 1; lcd_e high in cycles 2-4; iobus_out=0x38 with iobus_oe=1 throughout.
  - cpu_ack at cycle 5; busy high until cycle 25 (RECOVER=20).
- Scan read with iobus_in=0xA5: btn_rd high for 3 cycles, iobus_oe=0 throughout, scan_ack at cycle 5 with scan_din=0xA5.
- Simultaneous cpu_req (dev=1) and scan_req held high:
  - Grants alternate CPU, scan, CPU.
  - Each ack arrives 6 cycles after the previous one.
  - Exactly one ack per transfer; never two acks in the same cycle.
- CPU request during LCD RECOVER: no grant until RECOVER expires, then cpu_ack 5 cycles later.
- cpu_dev=3: cpu_ack the next cycle with cpu_din=0x00, ioen stays 000, no strobe asserted.
- rst asserted during STROBE of an LCD write:
  - Next cycle: lcd_e=0, ioen=000, iobus_oe=0, busy=0, no ack.
  - A fresh request afterwards completes normally.
